// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Each access is a req/ack transaction bounded by a timeout, then a one-cycle done pulse.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nxt;
    logic              owner;  // 1 = data path owns the access
    logic              last;   // 1 = data path was granted last
    logic [CNT_W-1:0]  cnt;
    logic              grant_any, grant_d, tmo_hit, finish;
    logic [DATA_W-1:0] rd_val;

    assign grant_any = if_req | d_req;
    // On contention the requester not granted last wins.
    assign grant_d   = d_req & (~if_req | ~last);
    assign tmo_hit   = (cnt == CNT_W'(TIMEOUT - 1));
    assign finish    = mem_ack | tmo_hit;
    assign rd_val    = (mem_ack & ~mem_wr) ? mem_rdata : '0;

    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = BUSY;
            BUSY:    if (finish) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner     <= 1'b0;
            last      <= 1'b0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grant_any) begin
                    mem_req  <= 1'b1;
                    owner    <= grant_d;
                    last     <= grant_d;
                    cnt      <= '0;
                    mem_addr <= grant_d ? d_addr : if_addr;
                    mem_wr   <= grant_d & d_wr;
                    if (grant_d) mem_wdata <= d_wdata;
                end
                BUSY: if (finish) begin
                    mem_req <= 1'b0;
                    mem_wr  <= 1'b0;
                    if (owner) begin
                        d_done  <= 1'b1;
                        d_rdata <= rd_val;
                    end else begin
                        if_done  <= 1'b1;
                        if_rdata <= rd_val;
                    end
                    // An ack on the final cycle still counts as a completion.
                    if (!mem_ack) err <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: begin
                    if_done <= 1'b0;
                    d_done  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory responder model feeds acks and a scoreboard
// queue holds the expected owner and read data for every done pulse.
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_done, if_stall, d_done, d_stall, mem_req, mem_wr, err;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { bit is_d; logic [DW-1:0] rdata; } exp_t;
    exp_t sb[$];

    logic [DW-1:0] mem [logic [AW-1:0]];
    bit            auto_en = 1'b0;
    int            ack_wait = 0;
    logic          man_ack = 1'b0;
    logic [DW-1:0] man_rdata = '0;
    int            wcnt = 0;

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] model_rd(logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(bit is_d, logic [DW-1:0] rd);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit is_d, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if ((is_d ? d_done : if_done) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk(is_d ? "d_done_seen" : "if_done_seen", 64'(at >= 0), 64'd1);
    endtask

    // Memory responder: acks after ack_wait cycles of mem_req, or follows manual drive.
    initial forever begin
        @(posedge clk); #2;
        if (!auto_en) begin
            mem_ack   = man_ack;
            mem_rdata = man_rdata;
            wcnt      = 0;
        end else if (mem_req === 1'b1) begin
            if (wcnt == ack_wait) begin
                mem_ack = 1'b1;
                if (mem_wr) begin
                    mem[mem_addr] = mem_wdata;
                    mem_rdata = 32'hFFFF_FFFF;
                end else begin
                    mem_rdata = model_rd(mem_addr);
                end
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    initial forever begin
        @(posedge clk); #3;
        if (rst === 1'b1 && (if_done === 1'b1 || d_done === 1'b1)) begin
            chk("sb_not_empty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_owner_d", 64'(d_done), 64'(e.is_d));
                chk("sb_owner_if", 64'(if_done), 64'(!e.is_d));
                chk("sb_rdata", 64'(e.is_d ? d_rdata : if_rdata), 64'(e.rdata));
                chk("sb_stall_low", 64'(e.is_d ? d_stall : if_stall), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int at, n;
        int times[4];
        int hi;

        mem[32'h100] = 32'hDEAD_BEEF;
        #1 rst = 1'b0;
        #2;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_done", 64'({if_done, d_done}), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single fetch, zero-wait ack
        auto_en = 1'b1; ack_wait = 0;
        if_addr = 32'h100; if_req = 1'b1;
        push(1'b0, 32'hDEAD_BEEF);
        #1;
        chk("t1_c0_stall", 64'(if_stall), 64'd1);
        chk("t1_c0_mem_req", 64'(mem_req), 64'd0);
        @(posedge clk); #1;
        chk("t1_c1_mem_req", 64'(mem_req), 64'd1);
        chk("t1_c1_mem_addr", 64'(mem_addr), 64'h100);
        chk("t1_c1_mem_wr", 64'(mem_wr), 64'd0);
        chk("t1_c1_stall", 64'(if_stall), 64'd1);
        @(posedge clk); #1;
        chk("t1_c2_mem_req", 64'(mem_req), 64'd0);
        chk("t1_c2_done", 64'(if_done), 64'd1);
        chk("t1_c2_rdata", 64'(if_rdata), 64'hDEAD_BEEF);
        chk("t1_c2_stall", 64'(if_stall), 64'd0);
        if_req = 1'b0;
        @(posedge clk); #1;
        chk("t1_c3_done", 64'(if_done), 64'd0);

        // Contention, both held: D, I, D, I, 3 cycles apart
        d_addr = 32'h200; d_wr = 1'b0; if_addr = 32'h300;
        push(1'b1, ~32'h200); push(1'b0, ~32'h300);
        push(1'b1, ~32'h200); push(1'b0, ~32'h300);
        d_req = 1'b1; if_req = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (d_done === 1'b1 || if_done === 1'b1) begin
                times[n] = cyc;
                n++;
                if (n == 4) begin
                    d_req = 1'b0; if_req = 1'b0;
                    break;
                end
            end
        end
        chk("t3_done_count", 64'(n), 64'd4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("t3_spacing_%0d", i), 64'(times[i] - times[i-1]), 64'd3);
        @(posedge clk); #1;

        // Data write with 3 wait cycles
        ack_wait = 3;
        d_addr = 32'h40; d_wdata = 32'h1234_5678; d_wr = 1'b1; d_req = 1'b1;
        push(1'b1, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("t2_mem_req_c%0d", c), 64'(mem_req), 64'(c <= 4));
            chk($sformatf("t2_mem_wr_c%0d", c), 64'(mem_wr), 64'(c <= 4));
            if (c == 1) begin
                chk("t2_mem_addr", 64'(mem_addr), 64'h40);
                chk("t2_mem_wdata", 64'(mem_wdata), 64'h1234_5678);
            end
        end
        chk("t2_c5_done", 64'(d_done), 64'd1);
        chk("t2_c5_rdata", 64'(d_rdata), 64'd0);
        d_req = 1'b0; d_wr = 1'b0;
        @(posedge clk); #1;

        // Timeout: ack never comes
        auto_en = 1'b0; man_ack = 1'b0;
        chk("t4_err_before", 64'(err), 64'd0);
        if_addr = 32'h500; if_req = 1'b1;
        push(1'b0, 32'h0);
        hi = 0; at = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (mem_req === 1'b1) hi++;
            if (if_done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk("t4_done_seen", 64'(at >= 0), 64'd1);
        chk("t4_req_cycles", 64'(hi), 64'(TMO));
        chk("t4_err", 64'(err), 64'd1);
        if_req = 1'b0;
        @(posedge clk); #1;

        // err is sticky across a later successful read
        auto_en = 1'b1; ack_wait = 1;
        d_addr = 32'h40; d_wr = 1'b0; d_req = 1'b1;
        push(1'b1, 32'h1234_5678);
        wait_done(1'b1, at);
        chk("t5_rdata", 64'(d_rdata), 64'h1234_5678);
        chk("t5_err_sticky", 64'(err), 64'd1);
        d_req = 1'b0;
        @(posedge clk); #1;

        // mem_ack in IDLE is ignored
        auto_en = 1'b0; man_ack = 1'b1; man_rdata = 32'h5555_AAAA;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("t6_idle_mem_req", 64'(mem_req), 64'd0);
            chk("t6_idle_done", 64'({if_done, d_done}), 64'd0);
        end
        man_ack = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset during BUSY
        d_addr = 32'h80; d_wdata = 32'hCAFE; d_wr = 1'b1; d_req = 1'b1;
        @(posedge clk); #1;
        chk("t7_busy", 64'(mem_req), 64'd1);
        @(posedge clk); #4;
        rst = 1'b0;
        #1;
        chk("t7_mem_req", 64'(mem_req), 64'd0);
        chk("t7_mem_wr", 64'(mem_wr), 64'd0);
        chk("t7_mem_addr", 64'(mem_addr), 64'd0);
        chk("t7_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("t7_if_rdata", 64'(if_rdata), 64'd0);
        chk("t7_d_rdata", 64'(d_rdata), 64'd0);
        chk("t7_done", 64'({if_done, d_done}), 64'd0);
        chk("t7_err", 64'(err), 64'd0);
        d_req = 1'b0; d_wr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Fetch after reset, then contention grants data first
        auto_en = 1'b1; ack_wait = 0;
        if_addr = 32'h100; if_req = 1'b1;
        push(1'b0, 32'hDEAD_BEEF);
        wait_done(1'b0, at);
        chk("t8_rdata", 64'(if_rdata), 64'hDEAD_BEEF);
        chk("t8_err_clear", 64'(err), 64'd0);
        if_req = 1'b0;
        @(posedge clk); #1;

        d_addr = 32'h600; if_addr = 32'h700;
        push(1'b1, ~32'h600); push(1'b0, ~32'h700);
        d_req = 1'b1; if_req = 1'b1;
        wait_done(1'b1, at);
        chk("t9_if_not_first", 64'(if_done), 64'd0);
        d_req = 1'b0;
        wait_done(1'b0, at);
        if_req = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single-ported backing memory between the instruction-fetch path and the data-access path of the RISC-V core. The block arbitrates alternately when both request, sequences each access as a req/ack transaction on the memory port, and returns read data with a one-cycle done pulse. It generates the stall signals that freeze the pipeline while an access is outstanding, and it bounds every access with a timeout.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 15, legal range ≥1: maximum number of cycles `mem_req` is held waiting for `mem_ack`.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `if_req` input 1: fetch request. Held with `if_addr` until `if_done`.
- `if_addr` input ADDR_W: fetch address.
- `if_rdata` output DATA_W: fetch read data, valid while `if_done` is high.
- `if_done` output 1: one-cycle completion pulse for the fetch request.
- `if_stall` output 1: equals `if_req & ~if_done`.
- `d_req` input 1: data request. Held with the other `d_*` inputs until `d_done`.
- `d_wr` input 1: 1 = write, 0 = read.
- `d_addr` input ADDR_W: data address.
- `d_wdata` input DATA_W: data to write.
- `d_rdata` output DATA_W: data read data, valid while `d_done` is high (0 on a write).
- `d_done` output 1: one-cycle completion pulse for the data request.
- `d_stall` output 1: equals `d_req & ~d_done`.
- `mem_req` output 1: memory request, registered.
- `mem_wr` output 1: memory write enable, registered.
- `mem_addr` output ADDR_W: memory address, registered.
- `mem_wdata` output DATA_W: memory write data, registered.
- `mem_ack` input 1: memory completion, sampled while `mem_req` is high.
- `mem_rdata` input DATA_W: memory read data, valid with `mem_ack`.
- `err` output 1: sticky timeout flag, cleared only by reset.

## Operation
- States:
  - IDLE: no access outstanding; the only state that arbitrates.
  - BUSY: `mem_req` high, waiting for `mem_ack`.
  - RESP: the done pulse is asserted.
- Arbitration happens only in IDLE.
  - Only one requester active: grant it.
  - Both active: grant the requester that was *not* granted last. The `last` register resets to "fetch", so data wins the first contention.
- Grant edge (IDLE→BUSY):
  - Latch the granted address into `mem_addr`; for a data grant also latch `d_wr` into `mem_wr` and `d_wdata` into `mem_wdata`. For a fetch grant, `mem_wr`=0.
  - Set `mem_req`=1, load `owner`, update `last`, clear the timeout counter.
- BUSY, `mem_ack`=1 at an edge:
  - `mem_req` and `mem_wr` go to 0.
  - The owner's rdata register loads `mem_rdata` (0 for writes).
  - The owner's done goes to 1 and the state moves to RESP.
- BUSY, `mem_ack`=0: the counter increments. At the edge where counter == TIMEOUT-1:
  - `mem_req` goes to 0.
  - The owner's rdata loads 0.
  - The owner's done goes to 1, `err` is set to 1, and the state moves to RESP.
- RESP→IDLE unconditionally, clearing done. A requester may change or reassert its request in the RESP cycle; it is not considered until IDLE.
- A request that drops before done is a protocol violation. The access already issued still completes, and its done pulse is still produced.
- The counter width is the minimum needed to hold TIMEOUT-1, i.e. $clog2(TIMEOUT) with a minimum of 1 bit.

## Timing
- Reset: asserted asynchronously at any time, including mid-BUSY.
  - State → IDLE; `last` → fetch.
  - All outputs go to 0: `mem_req`, `mem_wr`, `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata`, `if_done`, `d_done`, `err`.
  - The in-flight access is abandoned.
- Latency, with the request presented in IDLE at cycle 0 and ack arriving k cycles after `mem_req` rises (k≥0):
  - `mem_req` is high in cycles 1..1+k.
  - done is high in cycle 2+k.
  - IDLE is reached in cycle 3+k.
- Minimum occupancy is 3 cycles per transaction.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, and done follows in the next cycle.
- Stall outputs are combinational from `*_req` and registered done. Stall is low in the done cycle.
- `mem_ack` is ignored in IDLE and RESP.

## Test plan
- Single fetch, `if_addr`=0x100, `mem_ack` in the first `mem_req` cycle, `mem_rdata`=0xDEADBEEF → `mem_req` in cycle 1 only; cycle 2 `if_done`=1 and `if_rdata`=0xDEADBEEF; `if_stall` high in cycles 0–1.
- Data write, `d_addr`=0x40, `d_wdata`=0x12345678, ack after 3 wait cycles → `mem_wr`=1 and `mem_req` high in cycles 1–4; `d_done` in cycle 5; `d_rdata`=0.
- Both requesters held high continuously, zero-wait ack → grants alternate D, I, D, I, and `d_done`/`if_done` pulses occur 3 cycles apart.
- `TIMEOUT`=15, `mem_ack` never asserted → `mem_req` high for exactly 15 cycles, then done with rdata=0 and `err`=1. `err` stays 1 through later successful accesses until reset.
- `rst` driven low during BUSY → all outputs are 0 immediately without a clock edge. After release, a fetch request completes normally, and under contention data is granted first.
- `mem_ack` pulsed while in IDLE → no state change and no done pulse.
